jtopl_chreg: RTL and testbench

Parametrised per-channel register store and slot sequencer for the OPL family, generalised from 9 channels to 3·GROUPS channels (OPL2 = 3 groups, OPL3 = 6 groups). It generates the slot counter that steps the operator pipeline. It holds each channel's F-number, block, key-on, feedback and connection, and presents them in pipeline order. CPU writes are posted: the block captures a write, asserts `busy`, and commits it when the sequencer reaches the target channel. It sits between the CPU register decoder and the PG/EG/operator stages.

---
 rtl/jtopl_chreg.sv | 196 +++++++++++++++++++
 tb/tb_jtopl_chreg.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_chreg.sv
// Per-channel OPL register store and slot sequencer for 3*GROUPS channels.
// Optional 4-op pairing storage is enabled by defining JTOPL_4OP_EN.
module jtopl_chreg #(
    parameter int GROUPS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [7:0] din,
    input  logic [2:0] sel_group,
    input  logic [1:0] sel_sub,
    input  logic       up_fnum_lo,
    input  logic       up_fnum_hi,
    input  logic       up_fbcon,
    input  logic       up_4op,
    output logic       busy,
    output logic       zero,
    output logic [2:0] group,
    output logic [2:0] subslot,
    output logic       op,
    output logic [9:0] fnum_I,
    output logic [2:0] block_I,
    output logic       keyon_I,
    output logic [2:0] fb_I,
    output logic       con_I,
    output logic       conn4_I
);

    localparam int NCH = 3 * GROUPS;
    localparam int CHW = $clog2(NCH);

    localparam logic [1:0] KIND_FHI   = 2'd0;
    localparam logic [1:0] KIND_FBCON = 2'd1;
    localparam logic [1:0] KIND_4OP   = 2'd2;

    logic [2:0] r_group;
    logic [2:0] r_subslot;

    logic       r_busy;
    logic [1:0] r_kind;
    logic [5:0] r_data;
    logic [2:0] r_sel_group;
    logic [1:0] r_sel_sub;
    logic [7:0] r_fnum_lo;

    logic [9:0] r_fnum  [0:NCH-1];
    logic [2:0] r_block [0:NCH-1];
    logic       r_keyon [0:NCH-1];
    logic [2:0] r_fb    [0:NCH-1];
    logic       r_con   [0:NCH-1];

    logic           w_strobe_4op;
    logic           w_capture;
    logic           w_commit;
    logic [1:0]     w_kind;
    logic [2:0]     w_sub_mod;
    logic [CHW-1:0] w_ch;
    logic [CHW-1:0] w_wr_ch;
    logic           w_last_sub;
    logic           w_last_group;

`ifdef JTOPL_4OP_EN
    assign w_strobe_4op = up_4op;
`else
    assign w_strobe_4op = 1'b0;
`endif

    assign w_last_sub   = (r_subslot == 3'd5);
    assign w_last_group = (r_group == 3'(GROUPS - 1));
    assign w_sub_mod    = (r_subslot >= 3'd3) ? r_subslot - 3'd3 : r_subslot;
    assign w_ch         = CHW'(int'(r_group) * 3 + int'(w_sub_mod));
    assign w_wr_ch      = CHW'(int'(r_sel_group) * 3 + int'(r_sel_sub));

    // Only one write may be in flight; later strobes are dropped, not queued.
    assign w_capture = !r_busy && (up_fnum_hi || up_fbcon || w_strobe_4op);
    // An out-of-range group never equals r_group, so such a write stays pending.
    assign w_commit  = cen && r_busy && (r_group == r_sel_group)
                     && (r_subslot == {1'b0, r_sel_sub});

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_kind = KIND_4OP;
        if (up_fnum_hi)
            w_kind = KIND_FHI;
        else if (up_fbcon)
            w_kind = KIND_FBCON;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_group   <= 3'd0;
            r_subslot <= 3'd0;
        end else if (cen) begin
            if (w_last_sub) begin
                r_subslot <= 3'd0;
                r_group   <= w_last_group ? 3'd0 : r_group + 3'd1;
            end else begin
                r_subslot <= r_subslot + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_kind      <= KIND_FHI;
            r_data      <= 6'd0;
            r_sel_group <= 3'd0;
            r_sel_sub   <= 2'd0;
            r_fnum_lo   <= 8'd0;
        end else begin
            if (up_fnum_lo)
                r_fnum_lo <= din;
            if (w_capture) begin
                r_busy      <= 1'b1;
                r_kind      <= w_kind;
                r_data      <= din[5:0];
                r_sel_group <= sel_group;
                r_sel_sub   <= sel_sub;
            end else if (w_commit) begin
                r_busy <= 1'b0;
            end
        end
    end

    // NOTE: the channel store is reset explicitly because every field must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_fnum[i]  <= 10'd0;
                r_block[i] <= 3'd0;
                r_keyon[i] <= 1'b0;
                r_fb[i]    <= 3'd0;
                r_con[i]   <= 1'b0;
            end
        end else if (w_commit) begin
            case (r_kind)
                KIND_FHI: begin
                    r_fnum[w_wr_ch]  <= {r_data[1:0], r_fnum_lo};
                    r_block[w_wr_ch] <= r_data[4:2];
                    r_keyon[w_wr_ch] <= r_data[5];
                end
                KIND_FBCON: begin
                    r_fb[w_wr_ch]  <= r_data[3:1];
                    r_con[w_wr_ch] <= r_data[0];
                end
                default: ;
            endcase
        end
    end

`ifdef JTOPL_4OP_EN
    localparam int NPAIR      = NCH / 2;
    localparam int NPAIR_USED = (NPAIR < 6) ? NPAIR : 6;

    logic [NPAIR_USED-1:0] r_pair;
    logic                  w_unused;

    assign w_unused = ^din[7:6];

    always_ff @(posedge clk) begin
        if (rst)
            r_pair <= '0;
        else if (w_commit && r_kind == KIND_4OP)
            r_pair <= r_data[NPAIR_USED-1:0];
    end

    // Pair p joins channel c=(p/3)*9+(p%3) with channel c+3.
    always_comb begin
        conn4_I = 1'b0;
        for (int p = 0; p < NPAIR_USED; p++) begin
            if (r_pair[p] && (int'(w_ch) == (p / 3) * 9 + (p % 3)
                           || int'(w_ch) == (p / 3) * 9 + (p % 3) + 3))
                conn4_I = 1'b1;
        end
    end
`else
    logic w_unused;

    assign w_unused = ^{din[7:6], up_4op};
    assign conn4_I  = 1'b0;
`endif

    assign busy    = r_busy;
    assign group   = r_group;
    assign subslot = r_subslot;
    assign zero    = (r_group == 3'd0) && (r_subslot == 3'd0);
    assign op      = (r_subslot >= 3'd3);
    assign fnum_I  = r_fnum[w_ch];
    assign block_I = r_block[w_ch];
    assign keyon_I = r_keyon[w_ch];
    assign fb_I    = r_fb[w_ch];
    assign con_I   = r_con[w_ch];

endmodule

// File: tb/tb_jtopl_chreg.sv
// Self-checking bench for jtopl_chreg (GROUPS=6) against a slot-index model.
// Expected 4-op results follow JTOPL_4OP_EN as defined for the build.
module tb_jtopl_chreg;

    localparam int GROUPS = 6;
    localparam int NCH    = 3 * GROUPS;
    localparam int FRAME  = 6 * GROUPS;
`ifdef JTOPL_4OP_EN
    localparam bit HAS4 = 1'b1;
`else
    localparam bit HAS4 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, cen, up_fnum_lo, up_fnum_hi, up_fbcon, up_4op;
    logic [7:0] din;
    logic [2:0] sel_group;
    logic [1:0] sel_sub;
    logic       busy, zero, op, keyon_I, con_I, conn4_I;
    logic [2:0] group, subslot, block_I, fb_I;
    logic [9:0] fnum_I;

    int checks = 0;
    int errors = 0;

    jtopl_chreg #(.GROUPS(GROUPS)) dut (
        .clk(clk), .rst(rst), .cen(cen), .din(din),
        .sel_group(sel_group), .sel_sub(sel_sub),
        .up_fnum_lo(up_fnum_lo), .up_fnum_hi(up_fnum_hi),
        .up_fbcon(up_fbcon), .up_4op(up_4op),
        .busy(busy), .zero(zero), .group(group), .subslot(subslot), .op(op),
        .fnum_I(fnum_I), .block_I(block_I), .keyon_I(keyon_I),
        .fb_I(fb_I), .con_I(con_I), .conn4_I(conn4_I)
    );

    always #5 clk = ~clk;

    // Model: t is the frame slot index (group*6+subslot); a pending write
    // carries the number of cen ticks remaining until it commits.
    int t;
    int m_fnum [NCH];
    int m_block[NCH];
    int m_keyon[NCH];
    int m_fb   [NCH];
    int m_con  [NCH];
    bit [5:0] m_pair;
    int m_latch;
    bit m_pend;
    int m_cd;
    int m_kind;
    int m_ch;
    int m_data;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0d time=%0t)", name, act, exp, t, $time);
        end
    endtask

    task automatic model_step();
        bit pend_old;
        if (rst) begin
            t = 0; m_latch = 0; m_pend = 0; m_cd = 0; m_pair = '0;
            for (int i = 0; i < NCH; i++) begin
                m_fnum[i] = 0; m_block[i] = 0; m_keyon[i] = 0; m_fb[i] = 0; m_con[i] = 0;
            end
            return;
        end
        pend_old = m_pend;
        if (pend_old && cen && m_cd > 0) begin
            m_cd--;
            if (m_cd == 0) begin
                m_pend = 0;
                if (m_kind == 0) begin
                    m_fnum[m_ch]  = ((m_data & 3) << 8) | m_latch;
                    m_block[m_ch] = (m_data >> 2) & 7;
                    m_keyon[m_ch] = (m_data >> 5) & 1;
                end else if (m_kind == 1) begin
                    m_fb[m_ch]  = (m_data >> 1) & 7;
                    m_con[m_ch] = m_data & 1;
                end else begin
                    for (int p = 0; p < 6; p++)
                        if (p < NCH / 2) m_pair[p] = m_data[p];
                end
            end
        end
        if (!pend_old && (up_fnum_hi || up_fbcon || (HAS4 && up_4op))) begin
            m_pend = 1;
            m_kind = up_fnum_hi ? 0 : (up_fbcon ? 1 : 2);
            m_data = int'(din);
            m_ch   = int'(sel_group) * 3 + int'(sel_sub);
            if (int'(sel_group) >= GROUPS)
                m_cd = -1;
            else
                m_cd = ((int'(sel_group) * 6 + int'(sel_sub)) - (t + int'(cen)) + 2 * FRAME) % FRAME + 1;
        end
        if (up_fnum_lo) m_latch = int'(din);
        if (cen) t = (t + 1) % FRAME;
    endtask

    function automatic bit exp_conn4(int ch);
        bit r = 0;
        for (int p = 0; p < 6; p++)
            if (p < NCH / 2 && m_pair[p] && (ch == (p / 3) * 9 + p % 3 || ch == (p / 3) * 9 + p % 3 + 3))
                r = 1;
        return r;
    endfunction

    task automatic compare();
        int g, s, ch;
        g  = t / 6;
        s  = t % 6;
        ch = g * 3 + s % 3;
        check("group",   32'(group),   32'(g));
        check("subslot", 32'(subslot), 32'(s));
        check("zero",    32'(zero),    32'(t == 0));
        check("op",      32'(op),      32'(s >= 3));
        check("busy",    32'(busy),    32'(m_pend));
        check("fnum_I",  32'(fnum_I),  32'(m_fnum[ch]));
        check("block_I", 32'(block_I), 32'(m_block[ch]));
        check("keyon_I", 32'(keyon_I), 32'(m_keyon[ch]));
        check("fb_I",    32'(fb_I),    32'(m_fb[ch]));
        check("con_I",   32'(con_I),   32'(m_con[ch]));
        check("conn4_I", 32'(conn4_I), 32'(HAS4 ? exp_conn4(ch) : 1'b0));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        up_fnum_lo = 0; up_fnum_hi = 0; up_fbcon = 0; up_4op = 0;
    endtask

    task automatic run_to(int target);
        int n = 0;
        while (t != target && n < 200) begin
            cycle();
            n++;
        end
        check("run_to_reached", 32'(t), 32'(target));
    endtask

    initial begin
        t = 0;
        rst = 1; cen = 1; din = 0; sel_group = 0; sel_sub = 0;
        idle();
        repeat (2) cycle();
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_group", 32'(group), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fields", {fnum_I, block_I, keyon_I, fb_I, con_I, conn4_I}, 32'd0);
        rst = 0;

        repeat (FRAME) cycle();
        check("frame_zero", 32'(zero), 32'd1);

        // fnum_lo 0x5A then fnum_hi 0x2D to channel (group 1, sub 2)
        up_fnum_lo = 1; din = 8'h5A;
        cycle();
        idle(); up_fnum_hi = 1; din = 8'h2D; sel_group = 1; sel_sub = 2;
        cycle();
        idle(); up_fbcon = 1; din = 8'h0F;
        cycle();
        idle();
        check("busy_after_capture", 32'(busy), 32'd1);
        run_to(8);
        check("busy_before_commit", 32'(busy), 32'd1);
        cycle();
        check("busy_cleared", 32'(busy), 32'd0);
        run_to(11);
        check("lit_keyon", 32'(keyon_I), 32'd1);
        check("lit_block", 32'(block_I), 32'd3);
        check("lit_fnum",  32'(fnum_I),  32'h15A);
        repeat (2 * FRAME) cycle();
        run_to(8);
        check("fbcon_ignored", {fb_I, con_I}, 32'd0);

        // reset while a write to group 2 / sub 0 is pending
        up_fnum_hi = 1; din = 8'h3F; sel_group = 2; sel_sub = 0;
        cycle();
        idle();
        check("busy_pend2", 32'(busy), 32'd1);
        rst = 1;
        cycle();
        rst = 0;
        check("busy_after_rst", 32'(busy), 32'd0);
        repeat (FRAME) cycle();
        run_to(15);
        check("discarded", {keyon_I, block_I, fnum_I}, 32'd0);

        // unreachable group keeps busy high until reset
        up_fbcon = 1; din = 8'h0B; sel_group = 7; sel_sub = 1;
        cycle();
        idle();
        repeat (2 * FRAME) cycle();
        check("bad_group_busy", 32'(busy), 32'd1);
        rst = 1;
        cycle();
        rst = 0;

        // 4-op pairing: pair 0 joins channels 0 and 3
        up_4op = 1; din = 8'h01; sel_group = 0; sel_sub = 0;
        cycle();
        idle();
        check("busy_4op", 32'(busy), 32'(HAS4));
        repeat (FRAME) cycle();
        run_to(0);
        check("conn4_ch0", 32'(conn4_I), 32'(HAS4));
        cycle();
        check("conn4_ch1", 32'(conn4_I), 32'd0);
        run_to(6);
        check("conn4_ch3", 32'(conn4_I), 32'(HAS4));
        run_to(24);
        check("conn4_ch12", 32'(conn4_I), 32'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(399) == 0);
            cen        = ($urandom_range(3) != 0);
            din        = 8'($urandom);
            up_fnum_lo = ($urandom_range(5) == 0);
            up_fnum_hi = ($urandom_range(9) == 0);
            up_fbcon   = ($urandom_range(9) == 0);
            up_4op     = ($urandom_range(11) == 0);
            sel_group  = ($urandom_range(39) == 0) ? 3'd7 : 3'($urandom_range(GROUPS - 1));
            sel_sub    = 2'($urandom_range(2));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
